button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 131 +++++++++++++
 tb/tb_button_debouncer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Debounces a bouncy mechanical input: two-flop synchronizer followed by a
// four-state stability FSM that accepts a new level after N enabled stable samples.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  input  logic en,
  output logic dout,
  output logic dout_bar,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic                 s1_q, s2_q;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dout_q, dout_d;
  logic                 dout_bar_q;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  // Synchronizer runs every cycle, independent of the sample enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din_raw;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STABLE_LO;
      cnt_q      <= '0;
      dout_q     <= 1'b0;
      dout_bar_q <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      dout_bar_q <= ~dout_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  // A reversal of s2 is checked before the terminal count, so a reversal
  // coinciding with count N-1 rejects the candidate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      case (state_q)
        STABLE_LO: begin
          if (s2_q) begin
            state_d = WAIT_HI;
            cnt_d   = ONE;
          end else begin
            cnt_d = '0;
          end
        end
        WAIT_HI: begin
          if (!s2_q) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        STABLE_HI: begin
          if (!s2_q) begin
            state_d = WAIT_LO;
            cnt_d   = ONE;
          end else begin
            cnt_d = '0;
          end
        end
        WAIT_LO: begin
          if (s2_q) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign dout     = dout_q;
  assign dout_bar = dout_bar_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign busy     = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with N=4; inputs change 1 time unit
// after each rising edge, so "edge k" is the k-th edge after the change.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din_raw = 1'b0;
  logic en = 1'b1;
  logic dout, dout_bar, rise, fall, busy;

  int total = 0;
  int bad   = 0;

  button_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .din_raw  (din_raw),
    .en       (en),
    .dout     (dout),
    .dout_bar (dout_bar),
    .rise     (rise),
    .fall     (fall),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_raw = 1'b0;
    en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din_raw = 1'b1;
    en = 1'b1;
    tick();
    tick();
    total++;
    if ({dout, dout_bar, rise, fall, busy} !== 5'b01000) begin
      bad++;
      $display("FAIL reset_state got=%b want=01000", {dout, dout_bar, rise, fall, busy});
    end
    din_raw = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({dout, dout_bar, busy} !== 3'b010) begin
      bad++;
      $display("FAIL reset_release got=%b want=010", {dout, dout_bar, busy});
    end
  endtask

  task automatic test_clean_rise();
    din_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      total++;
      if (dout !== (e >= 6) || dout_bar !== (e < 6) || rise !== (e == 6) || fall !== 1'b0) begin
        bad++;
        $display("FAIL clean_rise edge=%0d got dout=%b bar=%b rise=%b fall=%b want dout=%b bar=%b rise=%b fall=0",
                 e, dout, dout_bar, rise, fall, e >= 6, e < 6, e == 6);
      end
      total++;
      if (busy !== (e >= 3 && e <= 5)) begin
        bad++;
        $display("FAIL clean_rise_busy edge=%0d got=%b want=%b", e, busy, (e >= 3 && e <= 5));
      end
    end
  endtask

  task automatic test_fall();
    din_raw = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      total++;
      if (dout !== (e < 6) || dout_bar !== (e >= 6) || fall !== (e == 6) || rise !== 1'b0) begin
        bad++;
        $display("FAIL fall_step edge=%0d got dout=%b bar=%b rise=%b fall=%b want dout=%b bar=%b rise=0 fall=%b",
                 e, dout, dout_bar, rise, fall, e < 6, e >= 6, e == 6);
      end
    end
  endtask

  task automatic test_glitch();
    int busy_seen = 0;
    for (int e = 1; e <= 10; e++) begin
      din_raw = (e <= 3);
      tick();
      if (busy) busy_seen++;
      total++;
      if (dout !== 1'b0 || dout_bar !== 1'b1 || rise !== 1'b0) begin
        bad++;
        $display("FAIL glitch edge=%0d got dout=%b bar=%b rise=%b want dout=0 bar=1 rise=0",
                 e, dout, dout_bar, rise);
      end
    end
    total++;
    if (busy_seen !== 3) begin
      bad++;
      $display("FAIL glitch_busy_cycles got=%0d want=3", busy_seen);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat = 5'b10110;
    int rises = 0;
    for (int t = 1; t <= 14; t++) begin
      din_raw = (t <= 5) ? pat[5 - t] : 1'b1;
      tick();
      if (rise) rises++;
      total++;
      if (dout !== (t >= 11) || dout_bar !== (t < 11)) begin
        bad++;
        $display("FAIL bounce edge=%0d got dout=%b bar=%b want dout=%b bar=%b",
                 t - 5, dout, dout_bar, t >= 11, t < 11);
      end
    end
    total++;
    if (rises !== 1) begin
      bad++;
      $display("FAIL bounce_rise_count got=%0d want=1", rises);
    end
  endtask

  task automatic test_enable();
    do_reset();
    tick();
    din_raw = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      en = (t % 3 == 0);
      tick();
      total++;
      if (dout !== (t >= 12) || rise !== (t == 12) || fall !== 1'b0 || dout_bar !== (t < 12)) begin
        bad++;
        $display("FAIL enable_tick t=%0d got dout=%b rise=%b fall=%b bar=%b want dout=%b rise=%b fall=0 bar=%b",
                 t, dout, rise, fall, dout_bar, t >= 12, t == 12, t < 12);
      end
      total++;
      if (busy !== (t >= 3 && t <= 11)) begin
        bad++;
        $display("FAIL enable_busy t=%0d got=%b want=%b", t, busy, (t >= 3 && t <= 11));
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    tick();
    din_raw = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midwait_pre_busy got=%b want=1", busy);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({dout, dout_bar, busy, rise, fall} !== 5'b01000) begin
      bad++;
      $display("FAIL midwait_reset got=%b want=01000", {dout, dout_bar, busy, rise, fall});
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      total++;
      if (dout !== (e >= 6) || dout_bar !== (e < 6) || rise !== (e == 6) || fall !== 1'b0) begin
        bad++;
        $display("FAIL midwait_reaccept edge=%0d got dout=%b bar=%b rise=%b fall=%b want dout=%b bar=%b rise=%b fall=0",
                 e, dout, dout_bar, rise, fall, e >= 6, e < 6, e == 6);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_fall();
    test_glitch();
    test_bounce();
    test_enable();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
